// File: rtl/di_ram_terminal_if.sv
// DI-bus signal bundle between a host-interface bridge (master) and a
// responder terminal (slave).
interface di_ram_terminal_if;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic        di_read_mode;
    logic        di_read_req;
    logic        di_read;
    logic        di_read_rdy;
    logic [31:0] di_reg_datao;
    logic        di_write_mode;
    logic        di_write;
    logic        di_write_rdy;
    logic [31:0] di_reg_datai;
    logic [15:0] di_transfer_status;

    modport master (
        output di_term_addr, di_reg_addr, di_len,
        output di_read_mode, di_read_req, di_read,
        output di_write_mode, di_write, di_reg_datai,
        input  di_read_rdy, di_reg_datao, di_write_rdy, di_transfer_status
    );

    modport slave (
        input  di_term_addr, di_reg_addr, di_len,
        input  di_read_mode, di_read_req, di_read,
        input  di_write_mode, di_write, di_reg_datai,
        output di_read_rdy, di_reg_datao, di_write_rdy, di_transfer_status
    );
endinterface

// File: rtl/di_ram_terminal.sv
// DI-bus terminal backed by a 2^ADDR_WIDTH x 32 RAM with burst auto-increment.
// Define DI_RAM_TERMINAL_WRAP_EN to wrap the word pointer instead of range-checking it.
module di_ram_terminal #(
    parameter logic [15:0] TERM_ADDR    = 16'h0010,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic           ifclk,
    input logic           resetb,
    di_ram_terminal_if.slave di
);
    localparam logic [2:0]  S_IDLE     = 3'd0;
    localparam logic [2:0]  S_RD_FETCH = 3'd1;
    localparam logic [2:0]  S_RD_VALID = 3'd2;
    localparam logic [2:0]  S_WR_OPEN  = 3'd3;
    localparam logic [2:0]  S_WR_HOLD  = 3'd4;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [2:0]  LAT_INIT   = 3'(READ_LATENCY);

    logic [31:0] mem [DEPTH];

    logic [2:0]  state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] left_q, left_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] datao_q, datao_d;
    logic [15:0] status_q, status_d;
    logic        wsel_q, wsel_d;

    logic                  sel;
    logic                  ptr_oor;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           ptr_inc;
    logic [31:0]           start_ptr;
    logic [31:0]           len_eff;

    assign sel     = (di.di_term_addr == TERM_ADDR);
    assign idx     = ptr_q[ADDR_WIDTH-1:0];
    assign len_eff = (di.di_len == '0) ? 32'd1 : di.di_len;

`ifdef DI_RAM_TERMINAL_WRAP_EN
    localparam logic [31:0] PTR_MASK = 32'(DEPTH - 1);
    assign ptr_oor   = 1'b0;
    assign ptr_inc   = (ptr_q + 32'd1) & PTR_MASK;
    assign start_ptr = di.di_reg_addr & PTR_MASK;
`else
    assign ptr_oor   = (ptr_q >> ADDR_WIDTH) != '0;
    assign ptr_inc   = ptr_q + 32'd1;
    assign start_ptr = di.di_reg_addr;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        left_d   = left_q;
        lat_d    = lat_q;
        datao_d  = datao_q;
        status_d = status_q;
        mem_we   = 1'b0;
        wsel_d   = sel & di.di_write_mode;

        // A read request restarts from any state, so it is decoded ahead of the FSM.
        if (sel && di.di_read_req) begin
            ptr_d    = start_ptr;
            left_d   = len_eff;
            lat_d    = LAT_INIT;
            status_d = '0;
            state_d  = S_RD_FETCH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wsel_d && !wsel_q) begin
                        ptr_d    = start_ptr;
                        status_d = '0;
                        state_d  = S_WR_OPEN;
                    end
                end
                S_RD_FETCH: begin
                    if (!di.di_read_mode) begin
                        state_d = S_IDLE;
                    end else if (lat_q <= 3'd1) begin
                        datao_d = ptr_oor ? '0 : mem[idx];
                        if (ptr_oor) status_d = 16'h0001;
                        state_d = S_RD_VALID;
                    end else begin
                        lat_d = lat_q - 3'd1;
                    end
                end
                S_RD_VALID: begin
                    if (!di.di_read_mode) begin
                        state_d = S_IDLE;
                    end else if (sel && di.di_read) begin
                        ptr_d   = ptr_inc;
                        left_d  = left_q - 32'd1;
                        lat_d   = LAT_INIT;
                        state_d = (left_q != 32'd1) ? S_RD_FETCH : S_IDLE;
                    end
                end
                S_WR_OPEN: begin
                    if (!di.di_write_mode) begin
                        state_d = S_IDLE;
                    end else if (sel && di.di_write) begin
                        mem_we  = !ptr_oor;
                        if (ptr_oor) status_d = 16'h0001;
                        ptr_d   = ptr_inc;
                        state_d = S_WR_HOLD;
                    end
                end
                S_WR_HOLD: state_d = di.di_write_mode ? S_WR_OPEN : S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            left_q   <= '0;
            lat_q    <= '0;
            datao_q  <= '0;
            status_q <= '0;
            wsel_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            left_q   <= left_d;
            lat_q    <= lat_d;
            datao_q  <= datao_d;
            status_q <= status_d;
            wsel_q   <= wsel_d;
        end
    end

    always_ff @(posedge ifclk) begin
        if (mem_we) mem[idx] <= di.di_reg_datai;
    end

    assign di.di_read_rdy        = sel && (state_q == S_RD_VALID);
    assign di.di_write_rdy       = sel && (state_q == S_WR_OPEN);
    assign di.di_reg_datao       = sel ? datao_q : '0;
    assign di.di_transfer_status = status_q;
endmodule

// File: tb/tb_di_ram_terminal.sv
// Self-checking bench for di_ram_terminal: random transfers scored against a word-array model.
module tb_di_ram_terminal;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 256;
    localparam logic [15:0] TERM  = 16'h0010;
`ifdef DI_RAM_TERMINAL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic ifclk  = 1'b0;
    logic resetb = 1'b0;

    di_ram_terminal_if dif();

    di_ram_terminal #(
        .TERM_ADDR   (16'h0010),
        .ADDR_WIDTH  (8),
        .READ_LATENCY(2)
    ) dut (
        .ifclk (ifclk),
        .resetb(resetb),
        .di    (dif)
    );

    always #5 ifclk = ~ifclk;

    int total = 0;
    int bad   = 0;

    bit   [31:0] ref_mem [DEPTH];
    logic [31:0] wdata [$];
    int          wr_gap [$];
    logic [15:0] wr_stat;
    logic [31:0] rd_data [$];
    int          rd_gap [$];
    logic [15:0] rd_stat [$];
    bit          rd_hold_ok;
    logic        rd_end_rdy;

    function automatic bit ref_oor(input logic [31:0] a);
        return !WRAP && (a >= DEPTH);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (WRAP) return ref_mem[a % DEPTH];
        if (a >= DEPTH) return 32'h0;
        return ref_mem[a];
    endfunction

    function automatic void ref_wr(input logic [31:0] a, input logic [31:0] d);
        if (WRAP) ref_mem[a % DEPTH] = d;
        else if (a < DEPTH) ref_mem[a] = d;
    endfunction

    task automatic tick();
        @(posedge ifclk);
        #1;
    endtask

    task automatic idle_inputs();
        dif.di_term_addr  = TERM;
        dif.di_reg_addr   = '0;
        dif.di_len        = '0;
        dif.di_read_mode  = 1'b0;
        dif.di_read_req   = 1'b0;
        dif.di_read       = 1'b0;
        dif.di_write_mode = 1'b0;
        dif.di_write      = 1'b0;
        dif.di_reg_datai  = '0;
    endtask

    task automatic do_write(input logic [31:0] addr);
        int g;
        wr_gap.delete();
        dif.di_reg_addr   = addr;
        dif.di_write_mode = 1'b1;
        tick();
        foreach (wdata[i]) begin
            g = 0;
            while (dif.di_write_rdy !== 1'b1 && g < 20) begin
                tick();
                g++;
            end
            wr_gap.push_back(g);
            if (g >= 20) break;
            dif.di_reg_datai = wdata[i];
            dif.di_write     = 1'b1;
            tick();
            dif.di_write     = 1'b0;
        end
        wr_stat = dif.di_transfer_status;
        dif.di_write_mode = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] len, input int max_dly);
        int g;
        int n;
        int dly;
        logic [31:0] d;
        n = (len == 0) ? 1 : int'(len);
        rd_data.delete();
        rd_gap.delete();
        rd_stat.delete();
        rd_hold_ok = 1'b1;
        dif.di_reg_addr  = addr;
        dif.di_len       = len;
        dif.di_read_mode = 1'b1;
        dif.di_read_req  = 1'b1;
        tick();
        dif.di_read_req  = 1'b0;
        for (int i = 0; i < n; i++) begin
            g = 0;
            while (dif.di_read_rdy !== 1'b1 && g < 20) begin
                tick();
                g++;
            end
            rd_gap.push_back(g);
            if (g >= 20) break;
            d = dif.di_reg_datao;
            rd_data.push_back(d);
            rd_stat.push_back(dif.di_transfer_status);
            dly = $urandom_range(max_dly, 0);
            for (int k = 0; k < dly; k++) begin
                tick();
                if (dif.di_read_rdy !== 1'b1 || dif.di_reg_datao !== d) rd_hold_ok = 1'b0;
            end
            dif.di_read = 1'b1;
            tick();
            dif.di_read = 1'b0;
        end
        rd_end_rdy = dif.di_read_rdy;
        dif.di_read_mode = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        resetb = 1'b0;
        #1;
        total++; if (dif.di_read_rdy !== 1'b0) begin bad++; $display("FAIL reset_read_rdy got=%b exp=0", dif.di_read_rdy); end
        total++; if (dif.di_write_rdy !== 1'b0) begin bad++; $display("FAIL reset_write_rdy got=%b exp=0", dif.di_write_rdy); end
        total++; if (dif.di_reg_datao !== 32'h0) begin bad++; $display("FAIL reset_datao got=%h exp=0", dif.di_reg_datao); end
        total++; if (dif.di_transfer_status !== 16'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", dif.di_transfer_status); end
        tick();
        tick();
        resetb = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        wdata.delete();
        for (int i = 0; i < int'(DEPTH); i++) wdata.push_back($urandom);
        do_write(32'd0);
        foreach (wdata[i]) ref_wr(32'(i), wdata[i]);
        total++; if (wr_gap.size() != int'(DEPTH)) begin bad++; $display("FAIL fill_words got=%0d exp=%0d", wr_gap.size(), DEPTH); end
        foreach (wr_gap[i]) begin
            total++;
            if (wr_gap[i] !== ((i == 0) ? 0 : 1)) begin bad++; $display("FAIL fill_gap[%0d] got=%0d exp=%0d", i, wr_gap[i], (i == 0) ? 0 : 1); end
        end
        total++; if (wr_stat !== 16'h0) begin bad++; $display("FAIL fill_status got=%h exp=0", wr_stat); end
    endtask

    task automatic test_single();
        wdata.delete();
        wdata.push_back(32'hA5A5_0001);
        do_write(32'd5);
        ref_wr(32'd5, 32'hA5A5_0001);
        do_read(32'd5, 32'd1, 0);
        total++; if (rd_gap.size() != 1 || rd_gap[0] !== int'(LAT)) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", (rd_gap.size() > 0) ? rd_gap[0] : -1, LAT); end
        total++; if (rd_data.size() != 1 || rd_data[0] !== ref_rd(32'd5)) begin bad++; $display("FAIL single_data got=%h exp=%h", (rd_data.size() > 0) ? rd_data[0] : 32'hx, ref_rd(32'd5)); end
        total++; if (rd_stat.size() != 1 || rd_stat[0] !== 16'h0) begin bad++; $display("FAIL single_status got=%h exp=0", (rd_stat.size() > 0) ? rd_stat[0] : 16'hx); end
        total++; if (rd_end_rdy !== 1'b0) begin bad++; $display("FAIL single_rdy_fall got=%b exp=0", rd_end_rdy); end
    endtask

    task automatic test_burst();
        wdata.delete();
        for (int i = 1; i <= 4; i++) wdata.push_back(32'(i));
        do_write(32'd10);
        foreach (wdata[i]) ref_wr(32'd10 + 32'(i), wdata[i]);
        foreach (wr_gap[i]) begin
            total++;
            if (wr_gap[i] !== ((i == 0) ? 0 : 1)) begin bad++; $display("FAIL burst_wr_gap[%0d] got=%0d exp=%0d", i, wr_gap[i], (i == 0) ? 0 : 1); end
        end
        do_read(32'd10, 32'd4, 2);
        total++; if (rd_data.size() != 4) begin bad++; $display("FAIL burst_words got=%0d exp=4", rd_data.size()); end
        foreach (rd_data[i]) begin
            total++;
            if (rd_data[i] !== 32'(i + 1)) begin bad++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, rd_data[i], 32'(i + 1)); end
            total++;
            if (rd_gap[i] !== int'(LAT)) begin bad++; $display("FAIL burst_rd_gap[%0d] got=%0d exp=%0d", i, rd_gap[i], LAT); end
        end
        total++; if (rd_hold_ok !== 1'b1) begin bad++; $display("FAIL burst_hold got=%b exp=1", rd_hold_ok); end
    endtask

    task automatic test_wrong_term();
        int errs;
        errs = 0;
        dif.di_term_addr  = 16'h0011;
        dif.di_reg_addr   = 32'd5;
        dif.di_write_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            dif.di_write     = 1'b1;
            dif.di_reg_datai = 32'h0BAD_0BAD;
            if (dif.di_write_rdy !== 1'b0 || dif.di_reg_datao !== 32'h0) errs++;
        end
        dif.di_write      = 1'b0;
        dif.di_write_mode = 1'b0;
        dif.di_read_mode  = 1'b1;
        dif.di_read_req   = 1'b1;
        dif.di_len        = 32'd1;
        tick();
        dif.di_read_req   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dif.di_read = 1'b1;
            if (dif.di_read_rdy !== 1'b0 || dif.di_reg_datao !== 32'h0) errs++;
            tick();
        end
        dif.di_read      = 1'b0;
        dif.di_read_mode = 1'b0;
        tick();
        dif.di_term_addr = TERM;
        tick();
        total++; if (errs != 0) begin bad++; $display("FAIL wrong_term_quiet got=%0d exp=0", errs); end
        do_read(32'd5, 32'd1, 0);
        total++; if (rd_data.size() != 1 || rd_data[0] !== ref_rd(32'd5)) begin bad++; $display("FAIL wrong_term_ram got=%h exp=%h", (rd_data.size() > 0) ? rd_data[0] : 32'hx, ref_rd(32'd5)); end
    endtask

    task automatic test_boundary();
        logic [15:0] exp_st;
        exp_st = WRAP ? 16'h0 : 16'h1;
        do_read(32'd255, 32'd2, 1);
        total++; if (rd_data.size() != 2) begin bad++; $display("FAIL bound_words got=%0d exp=2", rd_data.size()); end
        else begin
            total++; if (rd_data[0] !== ref_rd(32'd255)) begin bad++; $display("FAIL bound_w0 got=%h exp=%h", rd_data[0], ref_rd(32'd255)); end
            total++; if (rd_data[1] !== ref_rd(32'd256)) begin bad++; $display("FAIL bound_w1 got=%h exp=%h", rd_data[1], ref_rd(32'd256)); end
            total++; if (rd_stat[0] !== 16'h0) begin bad++; $display("FAIL bound_st0 got=%h exp=0", rd_stat[0]); end
            total++; if (rd_stat[1] !== exp_st) begin bad++; $display("FAIL bound_st1 got=%h exp=%h", rd_stat[1], exp_st); end
        end
        wdata.delete();
        wdata.push_back($urandom);
        wdata.push_back($urandom);
        do_write(32'd255);
        foreach (wdata[i]) ref_wr(32'd255 + 32'(i), wdata[i]);
        total++; if (wr_stat !== exp_st) begin bad++; $display("FAIL bound_wr_status got=%h exp=%h", wr_stat, exp_st); end
        do_read(32'd0, 32'd1, 0);
        total++; if (rd_data.size() != 1 || rd_data[0] !== ref_rd(32'd0)) begin bad++; $display("FAIL bound_word0 got=%h exp=%h", (rd_data.size() > 0) ? rd_data[0] : 32'hx, ref_rd(32'd0)); end
    endtask

    task automatic test_abort();
        int errs;
        errs = 0;
        dif.di_reg_addr  = 32'd7;
        dif.di_len       = 32'd1;
        dif.di_read_mode = 1'b1;
        dif.di_read_req  = 1'b1;
        tick();
        dif.di_read_req  = 1'b0;
        dif.di_read_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dif.di_read_rdy !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL abort_no_rdy got=%0d exp=0", errs); end
        do_read(32'd7, 32'd1, 0);
        total++; if (rd_gap.size() != 1 || rd_gap[0] !== int'(LAT)) begin bad++; $display("FAIL abort_next_latency got=%0d exp=%0d", (rd_gap.size() > 0) ? rd_gap[0] : -1, LAT); end
        total++; if (rd_data.size() != 1 || rd_data[0] !== ref_rd(32'd7)) begin bad++; $display("FAIL abort_next_data got=%h exp=%h", (rd_data.size() > 0) ? rd_data[0] : 32'hx, ref_rd(32'd7)); end
    endtask

    task automatic test_reset_mid();
        int g;
        wdata.delete();
        wdata.push_back(32'hDEAD_BEEF);
        do_write(32'd200);
        ref_wr(32'd200, 32'hDEAD_BEEF);
        dif.di_reg_addr  = 32'd200;
        dif.di_len       = 32'd1;
        dif.di_read_mode = 1'b1;
        dif.di_read_req  = 1'b1;
        tick();
        dif.di_read_req  = 1'b0;
        g = 0;
        while (dif.di_read_rdy !== 1'b1 && g < 20) begin
            tick();
            g++;
        end
        total++; if (dif.di_reg_datao !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rstmid_pre_data got=%h exp=deadbeef", dif.di_reg_datao); end
        #2;
        resetb = 1'b0;
        #1;
        total++; if (dif.di_read_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_rdy got=%b exp=0", dif.di_read_rdy); end
        total++; if (dif.di_reg_datao !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", dif.di_reg_datao); end
        total++; if (dif.di_transfer_status !== 16'h0) begin bad++; $display("FAIL rstmid_status got=%h exp=0", dif.di_transfer_status); end
        dif.di_read_mode = 1'b0;
        tick();
        resetb = 1'b1;
        tick();
        tick();
        do_read(32'd200, 32'd1, 0);
        total++; if (rd_data.size() != 1 || rd_data[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rstmid_after got=%h exp=deadbeef", (rd_data.size() > 0) ? rd_data[0] : 32'hx); end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] len;
        logic [15:0] st;
        int n;
        for (int t = 0; t < 40; t++) begin
            addr = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(259, 250)) : 32'($urandom_range(259, 0));
            if ($urandom_range(1, 0) == 1) begin
                n = $urandom_range(4, 1);
                wdata.delete();
                st = 16'h0;
                for (int i = 0; i < n; i++) begin
                    wdata.push_back($urandom);
                    if (ref_oor(addr + 32'(i))) st = 16'h1;
                end
                do_write(addr);
                foreach (wdata[i]) ref_wr(addr + 32'(i), wdata[i]);
                total++; if (wr_gap.size() != n) begin bad++; $display("FAIL rnd%0d_wr_words got=%0d exp=%0d", t, wr_gap.size(), n); end
                total++; if (wr_stat !== st) begin bad++; $display("FAIL rnd%0d_wr_status got=%h exp=%h", t, wr_stat, st); end
            end else begin
                len = 32'($urandom_range(5, 0));
                n = (len == 0) ? 1 : int'(len);
                do_read(addr, len, 2);
                total++; if (rd_data.size() != n) begin bad++; $display("FAIL rnd%0d_rd_words got=%0d exp=%0d", t, rd_data.size(), n); end
                st = 16'h0;
                foreach (rd_data[i]) begin
                    if (ref_oor(addr + 32'(i))) st = 16'h1;
                    total++; if (rd_data[i] !== ref_rd(addr + 32'(i))) begin bad++; $display("FAIL rnd%0d_rd_data[%0d] got=%h exp=%h", t, i, rd_data[i], ref_rd(addr + 32'(i))); end
                    total++; if (rd_stat[i] !== st) begin bad++; $display("FAIL rnd%0d_rd_status[%0d] got=%h exp=%h", t, i, rd_stat[i], st); end
                    total++; if (rd_gap[i] !== int'(LAT)) begin bad++; $display("FAIL rnd%0d_rd_gap[%0d] got=%0d exp=%0d", t, i, rd_gap[i], LAT); end
                end
                total++; if (rd_hold_ok !== 1'b1) begin bad++; $display("FAIL rnd%0d_rd_hold got=%b exp=1", t, rd_hold_ok); end
                total++; if (rd_end_rdy !== 1'b0) begin bad++; $display("FAIL rnd%0d_rd_end got=%b exp=0", t, rd_end_rdy); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single();
        test_burst();
        test_wrong_term();
        test_boundary();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
